// File: rtl/i2c_reg_slave.sv
// ----------------------------------------------------------------------------
// i2c_reg_slave : I2C target exposing NUM_REGS 8-bit registers, auto-increment
// Revision 1.0  : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module i2c_reg_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h55,
  parameter int         NUM_REGS   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scl,
  inout  wire                   sda,
  output logic [NUM_REGS*8-1:0] reg_out,
  output logic [NUM_REGS-1:0]   wr_strobe,
  output logic                  debug_addr_match,
  output logic [3:0]            debug_state
);

  localparam int         PTR_W      = $clog2(NUM_REGS);
  localparam logic [7:0] NUM_REGS_B = 8'(NUM_REGS);

  typedef enum logic [3:0] {
    IDLE         = 4'd0,
    RX_DEV_ADDR  = 4'd1,
    DEV_ADDR_ACK = 4'd2,
    RX_PTR       = 4'd3,
    PTR_ACK      = 4'd4,
    RX_DATA      = 4'd5,
    RX_DATA_ACK  = 4'd6,
    TX_DATA      = 4'd7,
    TX_ACK_CHK   = 4'd8,
    WAIT_STOP    = 4'd9
  } state_t;

  state_t             state;
  logic [2:0]         scl_sync;
  logic [2:0]         sda_sync;
  logic [3:0]         bit_cnt;
  logic [7:0]         shreg;
  logic [6:0]         txb;
  logic               rw;
  logic               addr_match;
  logic               sda_low;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   ptr_next;
  logic [7:0]         regs [NUM_REGS];
  logic               scl_rise;
  logic               scl_fall;
  logic               start_det;
  logic               stop_det;
  logic               sda_s;
  logic [7:0]         rx_byte;

  assign sda       = sda_low ? 1'b0 : 1'bz;
  assign scl_rise  = scl_sync[1] & ~scl_sync[2];
  assign scl_fall  = ~scl_sync[1] & scl_sync[2];
  assign start_det = scl_sync[1] & ~sda_sync[1] & sda_sync[2];
  assign stop_det  = scl_sync[1] & sda_sync[1] & ~sda_sync[2];
  assign sda_s     = sda_sync[1];
  assign rx_byte   = {shreg[6:0], sda_s};
  assign ptr_next  = (ptr == PTR_W'(NUM_REGS - 1)) ? '0 : ptr + 1'b1;

  assign debug_addr_match = addr_match;
  assign debug_state      = state;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
    assign reg_out[i*8 +: 8] = regs[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= 3'b111;
      sda_sync <= 3'b111;
    end else begin
      scl_sync <= {scl_sync[1:0], scl};
      sda_sync <= {sda_sync[1:0], sda};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      txb        <= '0;
      rw         <= 1'b0;
      addr_match <= 1'b0;
      sda_low    <= 1'b0;
      ptr        <= '0;
      wr_strobe  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      wr_strobe <= '0;
      if (stop_det && state != IDLE) begin
        state      <= IDLE;
        sda_low    <= 1'b0;
        bit_cnt    <= '0;
        addr_match <= 1'b0;
      end else if (start_det) begin
        state   <= RX_DEV_ADDR;
        sda_low <= 1'b0;
        bit_cnt <= '0;
      end else begin
        case (state)
          RX_DEV_ADDR: if (scl_rise) begin
            shreg   <= rx_byte;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 4'd7) begin
              bit_cnt    <= '0;
              addr_match <= (rx_byte[7:1] == SLAVE_ADDR);
              rw         <= rx_byte[0];
              state      <= (rx_byte[7:1] == SLAVE_ADDR) ? DEV_ADDR_ACK : WAIT_STOP;
            end
          end
          // First falling edge drives ACK, the second ends the ACK clock.
          DEV_ADDR_ACK: if (scl_fall) begin
            if (!sda_low) begin
              sda_low <= 1'b1;
            end else if (rw) begin
              txb     <= regs[ptr][6:0];
              sda_low <= ~regs[ptr][7];
              bit_cnt <= 4'd1;
              state   <= TX_DATA;
            end else begin
              sda_low <= 1'b0;
              state   <= RX_PTR;
            end
          end
          RX_PTR: if (scl_rise) begin
            shreg   <= rx_byte;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 4'd7) begin
              bit_cnt <= '0;
              if (rx_byte < NUM_REGS_B) begin
                ptr   <= rx_byte[PTR_W-1:0];
                state <= PTR_ACK;
              end else begin
                state <= WAIT_STOP;
              end
            end
          end
          PTR_ACK: if (scl_fall) begin
            if (!sda_low) begin
              sda_low <= 1'b1;
            end else begin
              sda_low <= 1'b0;
              state   <= RX_DATA;
            end
          end
          RX_DATA: if (scl_rise) begin
            shreg   <= rx_byte;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 4'd7) begin
              bit_cnt <= '0;
              state   <= RX_DATA_ACK;
            end
          end
          RX_DATA_ACK: if (scl_fall) begin
            if (!sda_low) begin
              sda_low <= 1'b1;
            end else begin
              sda_low        <= 1'b0;
              regs[ptr]      <= shreg;
              wr_strobe[ptr] <= 1'b1;
              ptr            <= ptr_next;
              state          <= RX_DATA;
            end
          end
          // bit_cnt counts bits already placed on the bus; 0 means load a new byte.
          TX_DATA: if (scl_fall) begin
            if (bit_cnt == 4'd0) begin
              txb     <= regs[ptr][6:0];
              sda_low <= ~regs[ptr][7];
              bit_cnt <= 4'd1;
            end else if (bit_cnt == 4'd8) begin
              sda_low <= 1'b0;
              bit_cnt <= '0;
              state   <= TX_ACK_CHK;
            end else begin
              sda_low <= ~txb[6];
              txb     <= {txb[5:0], 1'b0};
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          TX_ACK_CHK: if (scl_rise) begin
            if (!sda_s) begin
              ptr     <= ptr_next;
              bit_cnt <= '0;
              state   <= TX_DATA;
            end else begin
              state <= WAIT_STOP;
            end
          end
          default: sda_low <= 1'b0;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_i2c_reg_slave.sv
// ----------------------------------------------------------------------------
// tb_i2c_reg_slave : bit-banged I2C master with a transaction-level register model
// Revision 1.0     : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_i2c_reg_slave;

  localparam int NR = 4;
  localparam int Q  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          m_scl = 1'b1;
  logic          m_sda_low = 1'b0;
  wire           sda_bus;
  logic [NR*8-1:0] reg_out;
  logic [NR-1:0] wr_strobe;
  logic          debug_addr_match;
  logic [3:0]    debug_state;

  int            errors = 0;
  int            checks = 0;
  int            scnt [NR];
  int            wcnt [NR];
  int            drove_cnt = 0;
  logic [7:0]    model [NR];
  int            model_ptr = 0;
  logic [7:0]    wbuf [4];

  pullup (sda_bus);
  assign sda_bus = m_sda_low ? 1'b0 : 1'bz;

  i2c_reg_slave #(.SLAVE_ADDR(7'h55), .NUM_REGS(NR)) dut (
    .clk              (clk),
    .rst              (rst),
    .scl              (m_scl),
    .sda              (sda_bus),
    .reg_out          (reg_out),
    .wr_strobe        (wr_strobe),
    .debug_addr_match (debug_addr_match),
    .debug_state      (debug_state)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < NR; i++) scnt[i] = 0;

  always @(negedge clk) begin
    for (int i = 0; i < NR; i++) if (wr_strobe[i]) scnt[i] = scnt[i] + 1;
    if (!m_sda_low && sda_bus === 1'b0) drove_cnt = drove_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wq();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0; m_scl = 1'b1; wq();
    m_sda_low = 1'b1; wq();
    m_scl = 1'b0; wq();
  endtask

  task automatic i2c_rstart();
    m_sda_low = 1'b0; wq();
    m_scl = 1'b1; wq();
    m_sda_low = 1'b1; wq();
    m_scl = 1'b0; wq();
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; wq();
    m_scl = 1'b1; wq();
    m_sda_low = 1'b0; wq();
    wq();
  endtask

  task automatic write_bit(input logic b);
    m_sda_low = ~b; wq();
    m_scl = 1'b1; wq(); wq();
    m_scl = 1'b0; wq();
  endtask

  task automatic read_bit(output logic b);
    m_sda_low = 1'b0; wq();
    m_scl = 1'b1; wq();
    b = sda_bus;
    wq();
    m_scl = 1'b0; wq();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(~ack);
  endtask

  task automatic check_regs();
    for (int i = 0; i < NR; i++) begin
      check_eq($sformatf("reg%0d", i), 32'(reg_out[i*8 +: 8]), 32'(model[i]));
      check_eq($sformatf("strobe_cnt%0d", i), 32'(scnt[i]), 32'(wcnt[i]));
    end
  endtask

  task automatic check_idle();
    check_eq("state_idle", 32'(debug_state), 32'd0);
    check_eq("match_clr", 32'(debug_addr_match), 32'd0);
  endtask

  task automatic do_write(input logic [7:0] dev, input logic [7:0] p, input int n);
    logic ack;
    logic match;
    logic pok;
    int   d0;
    match = (dev[7:1] == 7'h55);
    d0 = drove_cnt;
    i2c_start();
    write_byte(dev, ack);
    check_eq("dev_ack", 32'(ack), 32'(match));
    check_eq("addr_match", 32'(debug_addr_match), 32'(match));
    write_byte(p, ack);
    pok = match && (p < NR);
    check_eq("ptr_ack", 32'(ack), 32'(pok));
    if (pok) model_ptr = int'(p);
    for (int i = 0; i < n; i++) begin
      write_byte(wbuf[i], ack);
      check_eq("data_ack", 32'(ack), 32'(pok));
      if (pok) begin
        model[model_ptr] = wbuf[i];
        wcnt[model_ptr]++;
        model_ptr = (model_ptr + 1) % NR;
      end
    end
    i2c_stop();
    if (!match) check_eq("no_drive", 32'(drove_cnt - d0), 32'd0);
    check_idle();
    check_regs();
  endtask

  task automatic do_read(input logic [7:0] p, input int n);
    logic       ack;
    logic       pok;
    logic [7:0] d;
    i2c_start();
    write_byte(8'hAA, ack);
    check_eq("rd_dev_ack", 32'(ack), 32'd1);
    write_byte(p, ack);
    pok = (p < NR);
    check_eq("rd_ptr_ack", 32'(ack), 32'(pok));
    if (pok) model_ptr = int'(p);
    i2c_rstart();
    write_byte(8'hAB, ack);
    check_eq("rd_sr_ack", 32'(ack), 32'd1);
    for (int i = 0; i < n; i++) begin
      read_byte(d, i != n - 1);
      check_eq("rd_data", 32'(d), 32'(model[model_ptr]));
      if (i != n - 1) model_ptr = (model_ptr + 1) % NR;
    end
    check_eq("rd_release", 32'(sda_bus), 32'd1);
    i2c_stop();
    check_idle();
    check_regs();
  endtask

  initial begin
    logic       ack;
    logic       seen;
    logic [7:0] dev;
    int         kind;
    int         n;

    for (int i = 0; i < NR; i++) begin
      model[i] = 8'h00;
      wcnt[i]  = 0;
    end
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    wq();
    check_eq("rst_state", 32'(debug_state), 32'd0);
    check_eq("rst_regs", 32'(reg_out), 32'd0);
    check_eq("rst_strobe", 32'(wr_strobe), 32'd0);
    check_eq("rst_match", 32'(debug_addr_match), 32'd0);
    check_eq("rst_sda", 32'(sda_bus), 32'd1);

    wbuf[0] = 8'hA5;
    do_write(8'hAA, 8'h01, 1);
    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    do_write(8'hAA, 8'h03, 2);
    wbuf[0] = 8'h5A; wbuf[1] = 8'hC3;
    do_write(8'hAA, 8'h02, 2);
    do_read(8'h02, 2);
    wbuf[0] = 8'hFF;
    do_write(8'hAC, 8'h00, 1);
    wbuf[0] = 8'h33;
    do_write(8'hAA, 8'h07, 1);

    // STOP after four data bits: partial byte must be discarded.
    i2c_start();
    write_byte(8'hAA, ack);
    write_byte(8'h00, ack);
    model_ptr = 0;
    for (int i = 0; i < 4; i++) write_bit(1'b1);
    i2c_stop();
    check_idle();
    check_regs();

    for (int t = 0; t < 20; t++) begin
      kind = int'($urandom_range(0, 3));
      n    = int'($urandom_range(1, 4));
      for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
      case (kind)
        0, 1: do_write(8'hAA, 8'($urandom_range(0, 5)), n);
        2:    do_read(8'($urandom_range(0, 4)), int'($urandom_range(1, 3)));
        default: begin
          dev = {7'($urandom), 1'b0};
          if (dev[7:1] == 7'h55) dev = 8'hAC;
          do_write(dev, 8'($urandom_range(0, 3)), n);
        end
      endcase
    end

    // Reset while the slave is holding ACK low.
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(1'(8'hAA >> i));
    m_sda_low = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (sda_bus === 1'b0) seen = 1'b1;
    end
    check_eq("ack_seen", 32'(seen), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_sda_rel", 32'(sda_bus), 32'd1);
    m_scl = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < NR; i++) model[i] = 8'h00;
    model_ptr = 0;
    wq();
    check_idle();
    check_regs();
    do_read(8'h01, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/i2c_reg_slave.md
Name: i2c_reg_slave

Overview:
Parametrised I2C target that exposes NUM_REGS 8-bit registers to the I2C master over the shared SCL/SDA bus.
- Protocol: device address, register pointer byte, then write-data or read-data bytes; pointer auto-increments.
- Supports repeated START and read-back.
- Drop-in successor to the single-byte LED slave: reg_out[7:0] drives LED[7:0] at the top level; other registers are for future peripherals.

Parameters:
SLAVE_ADDR, 7'h55, 7-bit I2C target address
NUM_REGS, 4, number of 8-bit registers (2..16)
PTR_W, $clog2(NUM_REGS), internal pointer width (derived, not overridden)

Ports:
clk  input  1  100 MHz system clock
rst  input  1  synchronous, active-high reset
scl  input  1  I2C clock from master
sda  inout  1  I2C data; driven only low (ACK or data 0), otherwise 'z
reg_out  output  NUM_REGS*8  register file, reg i at [8i+7:8i]
wr_strobe  output  NUM_REGS  one-clk pulse on bit i when reg i is written
debug_addr_match  output  1  address matched in current transaction
debug_state  output  4  current FSM state encoding

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset (rst high at a clk edge): state IDLE, SDA released next clk, all registers 0x00, pointer 0, wr_strobe 0, debug_addr_match 0. Reset mid-transaction aborts it with no partial write.
- Input sampling: SCL and SDA pass through 3-flop synchronisers.
  - Edges are taken from sync[2:1].
  - START = SDA falling while SCL high; STOP = SDA rising while SCL high.
- States (encoding 0..9): IDLE, RX_DEV_ADDR, DEV_ADDR_ACK, RX_PTR, PTR_ACK, RX_DATA, RX_DATA_ACK, TX_DATA, TX_ACK_CHK, WAIT_STOP.
- Global priority, highest first: STOP, then START, then the per-state case.
  - STOP in any non-IDLE state: go to IDLE, release SDA, clear bit counter and addr_match.
  - START in any state, including a repeated START mid-transaction: go to RX_DEV_ADDR with bit counter 0 and SDA released. The pointer is retained.
- Bit reception: SDA is sampled on each SCL rising edge, MSB first, 8 bits per byte.
- Address phase: after bit 8, addr_match = (addr[7:1] == SLAVE_ADDR); the R/W bit is latched.
  - No match: go to WAIT_STOP, SDA never driven.
- ACK drive: on the SCL falling edge after bit 8, drive SDA low. Release it on the next SCL falling edge (end of the 9th clock).
- After the device-address ACK: R/W = 0 goes to RX_PTR; R/W = 1 goes to TX_DATA.
- RX_PTR: pointer byte received.
  - Value < NUM_REGS: ACK, load pointer, go to RX_DATA.
  - Otherwise: NACK (SDA not driven), go to WAIT_STOP.
- RX_DATA / RX_DATA_ACK: ACK every data byte.
  - At the SCL falling edge that ends the ACK clock: reg[ptr] updated, wr_strobe[ptr] pulses for one clk, ptr = (ptr+1) mod NUM_REGS.
  - Return to RX_DATA for the next byte.
- TX_DATA: the slave drives reg[ptr] MSB first.
  - Each bit is set up on the SCL falling edge. The first bit follows the falling edge that ends the address ACK.
  - A 1 bit means SDA released.
  - After the 8th bit, release SDA on the falling edge and go to TX_ACK_CHK.
- TX_ACK_CHK: sample the master's ACK on the SCL rising edge.
  - ACK (SDA = 0): ptr increments with wrap; return to TX_DATA.
  - NACK: go to WAIT_STOP.
- WAIT_STOP: SDA released; only STOP or START exits.
- Partial bytes cut by STOP or START are discarded; registers are unchanged.
- The slave never drives SDA high and never stretches SCL.
- Reads have no side effects on registers.

Test Plan:
- Write S, 0xAA, ptr 0x01, 0xA5, P -> three ACKs; reg_out[15:8] = 0xA5; wr_strobe = 4'b0010 for exactly one clk; other registers 0x00.
- Burst write with wrap, NUM_REGS = 4: S, 0xAA, ptr 0x03, 0x11, 0x22, P -> reg3 = 0x11, reg0 = 0x22, all bytes ACKed.
- Read with repeated START: preload reg2 = 0x5A and reg3 = 0xC3. Send S, 0xAA, ptr 0x02, Sr, 0xAB; master reads 2 bytes, ACK then NACK; P -> master receives 0x5A, 0xC3; slave releases SDA after the NACK; state IDLE after P.
- Non-matching address 0xAC (addr 0x56): S, 0xAC, 0x00, 0xFF, P -> SDA never driven; registers unchanged; debug_addr_match stays 0.
- Out-of-range pointer: S, 0xAA, 0x07, 0x33, P -> pointer byte NACKed; data byte NACKed; no wr_strobe; registers unchanged.
- Abort cases:
  - STOP after 4 data bits -> no register write; state IDLE.
  - rst asserted while the slave is driving ACK low -> SDA released one clk later; all registers 0x00.
